// File: rtl/warp_rr_arbiter_pkg.sv
// Shared GPGPU constants for the warp round-robin arbiter.
// Holds the default requester count and the derived index width.
package warp_rr_arbiter_pkg;

    localparam int WARP_NUM_REQ = 4;
    localparam int WARP_IDX_W   = $clog2(WARP_NUM_REQ);

endpackage

// File: rtl/warp_rr_arbiter_one2bin.sv
// One-hot to binary encoder for the arbiter grant index.
// A zero input encodes to index 0.
module warp_rr_arbiter_one2bin
    import warp_rr_arbiter_pkg::*;
#(
    parameter int N = WARP_NUM_REQ,
    parameter int W = WARP_IDX_W
) (
    input  logic [N-1:0] i_oh,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_oh[i]) begin
                o_idx = o_idx | W'(i);
            end
        end
    end

endmodule

// File: rtl/warp_rr_arbiter.sv
// Round-robin warp arbiter with a registered one-hot/binary grant.
// A single output register stage with valid/ready back-pressure.
module warp_rr_arbiter
    import warp_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = WARP_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] req_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam logic [2*NUM_REQ-1:0] ONE2 = {{(2*NUM_REQ-1){1'b0}}, 1'b1};

    logic                 r_valid;
    logic [NUM_REQ-1:0]   r_grant;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;

    logic                 w_load;
    logic                 w_any;
    logic [NUM_REQ-1:0]   w_mask;
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [2*NUM_REQ-1:0] w_iso;
    logic [NUM_REQ-1:0]   w_win;
    logic [IDX_W-1:0]     w_win_idx;
    logic [IDX_W-1:0]     w_ptr_nxt;

    assign w_load = !r_valid || out_ready;
    assign w_any  = |req;

    // Low half holds requests at or above ptr, high half all requests;
    // the lowest set bit of the pair is the round-robin winner.
    assign w_mask = {NUM_REQ{1'b1}} << r_ptr;
    assign w_dbl  = {req, req & w_mask};
    assign w_iso  = w_dbl & (~w_dbl + ONE2);
    assign w_win  = w_iso[NUM_REQ-1:0] | w_iso[2*NUM_REQ-1:NUM_REQ];

    warp_rr_arbiter_one2bin #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_one2bin (
        .i_oh  (w_win),
        .o_idx (w_win_idx)
    );

    assign w_ptr_nxt = (w_win_idx == IDX_W'(NUM_REQ - 1))
                     ? '0 : w_win_idx + 1'b1;

    assign req_ack = (w_load && !rst) ? w_win : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_grant <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_any;
            r_grant <= w_win;
            r_idx   <= w_win_idx;
            if (w_any) begin
                r_ptr <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = r_valid;
    assign grant_oh  = r_grant;
    assign grant_idx = r_idx;

endmodule
